ahb_lite_master_arbiter: RTL

//  N-master AHB-Lite arbiter/mux; replaces single-master tie-off (HGRANT=1, HBUSREQ=1) in the SoC core.

---
 rtl/ahb_lite_master_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/ahb_lite_master_arbiter.sv
// N-master AHB-Lite arbiter/mux: the address phase follows the granted owner and
// write data follows the data-phase owner. Define ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest-index requester wins (fixed priority).
module ahb_lite_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR_M,
  input  logic [NUM_MASTERS*2-1:0]      HTRANS_M,
  input  logic [NUM_MASTERS-1:0]        HWRITE_M,
  input  logic [NUM_MASTERS*3-1:0]      HSIZE_M,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA_M,
  output logic [NUM_MASTERS-1:0]        HREADY_M,
  output logic [NUM_MASTERS-1:0]        HGRANT_M,
  output logic [DATA_W-1:0]             HRDATA_M,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [DATA_W-1:0]             HWDATA,
  input  logic                          HREADY,
  input  logic [DATA_W-1:0]             HRDATA
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0]       r_aowner;
  logic [IDX_W-1:0]       r_downer;

  logic [ADDR_W-1:0]      w_addr  [NUM_MASTERS];
  logic [1:0]             w_trans [NUM_MASTERS];
  logic [2:0]             w_size  [NUM_MASTERS];
  logic [DATA_W-1:0]      w_wdata [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_other;
  logic [IDX_W-1:0]       w_winner;
  logic                   w_any;
  logic                   w_switch;

  genvar g;
  for (g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign w_addr[g]  = HADDR_M[g*ADDR_W +: ADDR_W];
    assign w_trans[g] = HTRANS_M[g*2 +: 2];
    assign w_size[g]  = HSIZE_M[g*3 +: 3];
    assign w_wdata[g] = HWDATA_M[g*DATA_W +: DATA_W];
    assign w_req[g]   = HTRANS_M[g*2+1];
  end

  assign HADDR    = w_addr[r_aowner];
  assign HTRANS   = w_trans[r_aowner];
  assign HWRITE   = HWRITE_M[r_aowner];
  assign HSIZE    = w_size[r_aowner];
  assign HWDATA   = w_wdata[r_downer];
  assign HRDATA_M = HRDATA;

  // Arbitration among requesters other than the current owner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_other  = w_req;
    w_other[r_aowner] = 1'b0;
    w_winner = r_aowner;
    w_any    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k < NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(r_aowner) + k) % NUM_MASTERS;
      if (!w_any && w_other[idx]) begin
        w_winner = IDX_W'(idx);
        w_any    = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_any && w_other[k]) begin
        w_winner = IDX_W'(k);
        w_any    = 1'b1;
      end
    end
`endif
  end

  // Handover only at an accepted IDLE from the owner, so bursts and wait states stay whole.
  assign w_switch = HREADY && (w_trans[r_aowner] == 2'b00) && w_any;

  always_comb begin
    HREADY_M = '0;
    HGRANT_M = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (IDX_W'(i) == r_aowner) begin
        HREADY_M[i] = HREADY;
        HGRANT_M[i] = 1'b1;
      end else begin
        HREADY_M[i] = ~w_req[i];
      end
    end
  end

  // The owner register is the arbitration state: it is OWNED while the owner drives
  // traffic and PARKED on the last owner when nobody else requests.
  always_ff @(posedge HCLK or posedge HRESET) begin
    // NOTE: sequential state uses non-blocking assignments so r_downer samples the
    // pre-edge r_aowner, not the value updated in this same block.
    if (HRESET) begin
      r_aowner <= '0;
      r_downer <= '0;
    end else if (HREADY) begin
      r_downer <= r_aowner;
      if (w_switch) r_aowner <= w_winner;
    end
  end

endmodule
